// File: rtl/stage3_fc_argmax.sv
// Final classifier stage: accumulates NUM_BEATS kernel partial sums per class,
// adds the per-class bias, emits each score and then the arg-max class of the frame.
module stage3_fc_argmax #(
  parameter int IN_BW     = 22,
  parameter int NUM_BEATS = 48,
  parameter int NUM_CLASS = 3,
  parameter int B_BW      = 16,
  parameter int ACC_BW    = IN_BW + $clog2(NUM_BEATS) + 1,
  parameter int CLS_BW    = $clog2(NUM_CLASS)
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      i_kernel_valid,
  input  logic [IN_BW-1:0]          i_kernel,
  input  logic [NUM_CLASS*B_BW-1:0] i_bias,
  input  logic                      i_clear,
  output logic                      o_score_valid,
  output logic [ACC_BW-1:0]         o_score,
  output logic [CLS_BW-1:0]         o_score_class,
  output logic                      o_result_valid,
  output logic [CLS_BW-1:0]         o_result_class,
  output logic [ACC_BW-1:0]         o_result_score,
  output logic                      o_busy
);

  localparam int BEAT_BW = $clog2(NUM_BEATS);
  localparam logic [BEAT_BW-1:0] LAST_BEAT  = BEAT_BW'(NUM_BEATS - 1);
  localparam logic [CLS_BW-1:0]  LAST_CLASS = CLS_BW'(NUM_CLASS - 1);

  typedef enum logic {S_IDLE, S_ACCUM} state_t;

  state_t                     state_q, state_d;
  logic [BEAT_BW-1:0]         beat_cnt_q, beat_cnt_d;
  logic [CLS_BW-1:0]          class_cnt_q, class_cnt_d;
  logic signed [ACC_BW-1:0]   acc_q, acc_d;
  logic signed [ACC_BW-1:0]   score_q, score_d;
  logic                       score_valid_q, score_valid_d;
  logic [CLS_BW-1:0]          score_class_q, score_class_d;
  logic signed [ACC_BW-1:0]   best_q, best_d;
  logic [CLS_BW-1:0]          best_idx_q, best_idx_d;
  logic                       result_valid_q, result_valid_d;
  logic [CLS_BW-1:0]          result_class_q, result_class_d;
  logic signed [ACC_BW-1:0]   result_score_q, result_score_d;

  logic [B_BW-1:0]            bias_sel;
  logic signed [ACC_BW-1:0]   kern_ext, bias_ext, acc_sum;
  logic                       last_beat, last_class;

  always_comb begin
    bias_sel = '0;
    for (int unsigned k = 0; k < NUM_CLASS; k++) begin
      if (class_cnt_q == CLS_BW'(k)) bias_sel = i_bias[k*B_BW +: B_BW];
    end
  end

  assign kern_ext   = {{(ACC_BW-IN_BW){i_kernel[IN_BW-1]}}, i_kernel};
  assign bias_ext   = {{(ACC_BW-B_BW){bias_sel[B_BW-1]}}, bias_sel};
  assign acc_sum    = acc_q + kern_ext;
  assign last_beat  = (beat_cnt_q == LAST_BEAT);
  assign last_class = (class_cnt_q == LAST_CLASS);

  always_comb begin
    state_d = state_q;
    if (i_clear)             state_d = S_IDLE;
    else if (i_kernel_valid) state_d = (last_beat && last_class) ? S_IDLE : S_ACCUM;
  end

  always_comb begin
    beat_cnt_d    = beat_cnt_q;
    class_cnt_d   = class_cnt_q;
    acc_d         = acc_q;
    score_d       = score_q;
    score_valid_d = 1'b0;
    score_class_d = score_class_q;
    if (i_clear) begin
      beat_cnt_d  = '0;
      class_cnt_d = '0;
    end else if (i_kernel_valid) begin
      // Beat 0 loads rather than adds, so consecutive classes need no bubble.
      acc_d = (beat_cnt_q == '0) ? kern_ext : acc_sum;
      if (last_beat) begin
        beat_cnt_d    = '0;
        class_cnt_d   = last_class ? '0 : class_cnt_q + 1'b1;
        score_d       = acc_sum + bias_ext;
        score_valid_d = 1'b1;
        score_class_d = class_cnt_q;
      end else begin
        beat_cnt_d = beat_cnt_q + 1'b1;
      end
    end
  end

  // A partial frame's best is never reported: class 0 of the next frame reloads it.
  always_comb begin
    best_d         = best_q;
    best_idx_d     = best_idx_q;
    result_valid_d = 1'b0;
    result_class_d = result_class_q;
    result_score_d = result_score_q;
    if (score_valid_q) begin
      if ((score_class_q == '0) || (score_q > best_q)) begin
        best_d     = score_q;
        best_idx_d = score_class_q;
      end
      if (score_class_q == LAST_CLASS) begin
        result_valid_d = 1'b1;
        result_class_d = best_idx_d;
        result_score_d = best_d;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q        <= S_IDLE;
      beat_cnt_q     <= '0;
      class_cnt_q    <= '0;
      acc_q          <= '0;
      score_q        <= '0;
      score_valid_q  <= 1'b0;
      score_class_q  <= '0;
      best_q         <= '0;
      best_idx_q     <= '0;
      result_valid_q <= 1'b0;
      result_class_q <= '0;
      result_score_q <= '0;
    end else begin
      state_q        <= state_d;
      beat_cnt_q     <= beat_cnt_d;
      class_cnt_q    <= class_cnt_d;
      acc_q          <= acc_d;
      score_q        <= score_d;
      score_valid_q  <= score_valid_d;
      score_class_q  <= score_class_d;
      best_q         <= best_d;
      best_idx_q     <= best_idx_d;
      result_valid_q <= result_valid_d;
      result_class_q <= result_class_d;
      result_score_q <= result_score_d;
    end
  end

  assign o_score_valid  = score_valid_q;
  assign o_score        = score_q;
  assign o_score_class  = score_class_q;
  assign o_result_valid = result_valid_q;
  assign o_result_class = result_class_q;
  assign o_result_score = result_score_q;
  assign o_busy         = (state_q == S_ACCUM);

endmodule

// File: tb/tb_stage3_fc_argmax.sv
// Bench for stage3_fc_argmax: directed and random frames against a per-frame
// sum/arg-max reference model, checking values, class indices and cycle timing.
module tb_stage3_fc_argmax;
  localparam int IN_BW  = 22;
  localparam int NB     = 4;
  localparam int NC     = 3;
  localparam int B_BW   = 16;
  localparam int ACC_BW = IN_BW + $clog2(NB) + 1;
  localparam int CLS_BW = $clog2(NC);

  logic                 clk = 1'b0;
  logic                 reset = 1'b1;
  logic                 i_kernel_valid = 1'b0;
  logic [IN_BW-1:0]     i_kernel = '0;
  logic [NC*B_BW-1:0]   i_bias = '0;
  logic                 i_clear = 1'b0;
  logic                 o_score_valid;
  logic [ACC_BW-1:0]    o_score;
  logic [CLS_BW-1:0]    o_score_class;
  logic                 o_result_valid;
  logic [CLS_BW-1:0]    o_result_class;
  logic [ACC_BW-1:0]    o_result_score;
  logic                 o_busy;

  stage3_fc_argmax #(.IN_BW(IN_BW), .NUM_BEATS(NB), .NUM_CLASS(NC), .B_BW(B_BW)) dut (
    .clk(clk), .reset(reset), .i_kernel_valid(i_kernel_valid), .i_kernel(i_kernel),
    .i_bias(i_bias), .i_clear(i_clear), .o_score_valid(o_score_valid), .o_score(o_score),
    .o_score_class(o_score_class), .o_result_valid(o_result_valid),
    .o_result_class(o_result_class), .o_result_score(o_result_score), .o_busy(o_busy)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct { longint v; int c; int t; } ev_t;
  typedef int frame_t [NB*NC];

  ev_t exp_s[$], obs_s[$], exp_r[$], obs_r[$];
  int  total = 0;
  int  bad = 0;
  int  bias_m [NC];
  bit  busy_ok;

  always @(negedge clk) begin
    ev_t e;
    if (o_score_valid) begin
      e.v = longint'($signed(o_score)); e.c = int'(o_score_class); e.t = cyc;
      obs_s.push_back(e);
    end
    if (o_result_valid) begin
      e.v = longint'($signed(o_result_score)); e.c = int'(o_result_class); e.t = cyc;
      obs_r.push_back(e);
    end
  end

  task automatic set_bias(input int b0, input int b1, input int b2);
    bias_m[0] = b0; bias_m[1] = b1; bias_m[2] = b2;
    i_bias = {B_BW'(b2), B_BW'(b1), B_BW'(b0)};
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clk); #1;
      i_kernel_valid = 1'b0; i_clear = 1'b0;
    end
  endtask

  // Drives the first n beats of f; the model predicts each completed class score
  // (sum of its beats plus bias) and, for a full frame, the first strict maximum.
  task automatic play(input frame_t f, input int n, input int gapmax);
    longint sc [NC];
    int gap, k, best;
    ev_t e;
    busy_ok = 1'b1;
    for (int i = 0; i < n; i++) begin
      gap = (gapmax > 0) ? int'($urandom_range(0, gapmax)) : 0;
      repeat (gap) begin
        @(posedge clk); #1;
        if (i > 0 && o_busy !== 1'b1) busy_ok = 1'b0;
        i_kernel_valid = 1'b0;
      end
      @(posedge clk); #1;
      if (i > 0 && o_busy !== 1'b1) busy_ok = 1'b0;
      i_kernel_valid = 1'b1;
      i_kernel = IN_BW'(f[i]);
      if (i % NB == NB - 1) begin
        k = i / NB;
        sc[k] = bias_m[k];
        for (int j = 0; j < NB; j++) sc[k] += f[k*NB + j];
        e.v = sc[k]; e.c = k; e.t = cyc + 1;
        exp_s.push_back(e);
        if (k == NC - 1) begin
          best = 0;
          for (int j = 1; j < NC; j++) if (sc[j] > sc[best]) best = j;
          e.v = sc[best]; e.c = best; e.t = cyc + 2;
          exp_r.push_back(e);
        end
      end
    end
  endtask

  task automatic test_reset();
    reset = 1'b1;
    set_bias(10, -5, 0);
    repeat (3) begin
      @(posedge clk); #1;
      i_kernel_valid = 1'b1; i_kernel = IN_BW'($urandom);
    end
    @(posedge clk); #1;
    i_kernel_valid = 1'b0;
    total += 7;
    if (o_score_valid !== 1'b0)  begin bad++; $display("FAIL reset score_valid: got %b want 0", o_score_valid); end
    if (o_score !== '0)          begin bad++; $display("FAIL reset score: got %0h want 0", o_score); end
    if (o_score_class !== '0)    begin bad++; $display("FAIL reset score_class: got %0d want 0", o_score_class); end
    if (o_result_valid !== 1'b0) begin bad++; $display("FAIL reset result_valid: got %b want 0", o_result_valid); end
    if (o_result_class !== '0)   begin bad++; $display("FAIL reset result_class: got %0d want 0", o_result_class); end
    if (o_result_score !== '0)   begin bad++; $display("FAIL reset result_score: got %0h want 0", o_result_score); end
    if (o_busy !== 1'b0)         begin bad++; $display("FAIL reset busy: got %b want 0", o_busy); end
    reset = 1'b0;
    idle(2);
    obs_s.delete(); obs_r.delete();
  endtask

  task automatic test_contiguous();
    frame_t f;
    f = '{1, 2, 3, 4, 5, 5, 5, 5, -1, -1, -1, -1};
    set_bias(10, -5, 0);
    play(f, NB*NC, 0);
    idle(5);
    total++;
    if (obs_s.size() != exp_s.size() || obs_r.size() != exp_r.size()) begin
      bad++; $display("FAIL contiguous count: got %0d/%0d want %0d/%0d", obs_s.size(), obs_r.size(), exp_s.size(), exp_r.size());
    end
    for (int i = 0; i < obs_s.size() && i < exp_s.size(); i++) begin
      total++;
      if (obs_s[i] != exp_s[i]) begin bad++; $display("FAIL contiguous score[%0d]: got %0d cls%0d @%0d want %0d cls%0d @%0d", i, obs_s[i].v, obs_s[i].c, obs_s[i].t, exp_s[i].v, exp_s[i].c, exp_s[i].t); end
    end
    for (int i = 0; i < obs_r.size() && i < exp_r.size(); i++) begin
      total++;
      if (obs_r[i] != exp_r[i]) begin bad++; $display("FAIL contiguous result[%0d]: got %0d cls%0d @%0d want %0d cls%0d @%0d", i, obs_r[i].v, obs_r[i].c, obs_r[i].t, exp_r[i].v, exp_r[i].c, exp_r[i].t); end
    end
    exp_s.delete(); obs_s.delete(); exp_r.delete(); obs_r.delete();
  endtask

  task automatic test_gaps();
    frame_t f;
    f = '{1, 2, 3, 4, 5, 5, 5, 5, -1, -1, -1, -1};
    set_bias(10, -5, 0);
    play(f, NB*NC, 5);
    @(posedge clk); #1;
    i_kernel_valid = 1'b0;
    total += 2;
    if (busy_ok !== 1'b1) begin bad++; $display("FAIL gaps busy_during_frame: got dropped want held 1"); end
    if (o_busy !== 1'b0)  begin bad++; $display("FAIL gaps busy_after_frame: got %b want 0", o_busy); end
    idle(5);
    total++;
    if (obs_s.size() != exp_s.size() || obs_r.size() != exp_r.size()) begin
      bad++; $display("FAIL gaps count: got %0d/%0d want %0d/%0d", obs_s.size(), obs_r.size(), exp_s.size(), exp_r.size());
    end
    for (int i = 0; i < obs_s.size() && i < exp_s.size(); i++) begin
      total++;
      if (obs_s[i] != exp_s[i]) begin bad++; $display("FAIL gaps score[%0d]: got %0d cls%0d @%0d want %0d cls%0d @%0d", i, obs_s[i].v, obs_s[i].c, obs_s[i].t, exp_s[i].v, exp_s[i].c, exp_s[i].t); end
    end
    for (int i = 0; i < obs_r.size() && i < exp_r.size(); i++) begin
      total++;
      if (obs_r[i] != exp_r[i]) begin bad++; $display("FAIL gaps result[%0d]: got %0d cls%0d @%0d want %0d cls%0d @%0d", i, obs_r[i].v, obs_r[i].c, obs_r[i].t, exp_r[i].v, exp_r[i].c, exp_r[i].t); end
    end
    exp_s.delete(); obs_s.delete(); exp_r.delete(); obs_r.delete();
  endtask

  task automatic test_tie();
    frame_t f;
    f = '{2, 3, 2, 3, 2, 2, 2, 2, 5, 5, 5, 5};
    set_bias(10, -5, 0);
    play(f, NB*NC, 0);
    idle(5);
    total++;
    if (obs_r.size() != 1 || exp_r.size() != 1) begin
      bad++; $display("FAIL tie count: got %0d want 1", obs_r.size());
    end else if (obs_r[0] != exp_r[0]) begin
      bad++; $display("FAIL tie result: got %0d cls%0d @%0d want %0d cls%0d @%0d", obs_r[0].v, obs_r[0].c, obs_r[0].t, exp_r[0].v, exp_r[0].c, exp_r[0].t);
    end
    for (int i = 0; i < obs_s.size() && i < exp_s.size(); i++) begin
      total++;
      if (obs_s[i] != exp_s[i]) begin bad++; $display("FAIL tie score[%0d]: got %0d cls%0d @%0d want %0d cls%0d @%0d", i, obs_s[i].v, obs_s[i].c, obs_s[i].t, exp_s[i].v, exp_s[i].c, exp_s[i].t); end
    end
    exp_s.delete(); obs_s.delete(); exp_r.delete(); obs_r.delete();
  endtask

  task automatic test_back_to_back();
    frame_t f1, f2;
    f1 = '{1, 2, 3, 4, 5, 5, 5, 5, -1, -1, -1, -1};
    f2 = '{1, 1, 1, 1, 0, 0, 0, 0, 100, 100, 100, 100};
    set_bias(10, -5, 0);
    play(f1, NB*NC, 0);
    play(f2, NB*NC, 0);
    idle(5);
    total++;
    if (obs_s.size() != exp_s.size() || obs_r.size() != exp_r.size()) begin
      bad++; $display("FAIL b2b count: got %0d/%0d want %0d/%0d", obs_s.size(), obs_r.size(), exp_s.size(), exp_r.size());
    end
    for (int i = 0; i < obs_s.size() && i < exp_s.size(); i++) begin
      total++;
      if (obs_s[i] != exp_s[i]) begin bad++; $display("FAIL b2b score[%0d]: got %0d cls%0d @%0d want %0d cls%0d @%0d", i, obs_s[i].v, obs_s[i].c, obs_s[i].t, exp_s[i].v, exp_s[i].c, exp_s[i].t); end
    end
    for (int i = 0; i < obs_r.size() && i < exp_r.size(); i++) begin
      total++;
      if (obs_r[i] != exp_r[i]) begin bad++; $display("FAIL b2b result[%0d]: got %0d cls%0d @%0d want %0d cls%0d @%0d", i, obs_r[i].v, obs_r[i].c, obs_r[i].t, exp_r[i].v, exp_r[i].c, exp_r[i].t); end
    end
    exp_s.delete(); obs_s.delete(); exp_r.delete(); obs_r.delete();
  endtask

  task automatic test_clear();
    frame_t f1, f2;
    f1 = '{50, 50, 50, 50, 60, 60, 60, 60, 70, 70, 70, 70};
    f2 = '{-3, 7, 1, 0, 9, 9, -2, 4, 6, 6, 6, 6};
    set_bias(10, -5, 0);
    play(f1, 6, 0);
    @(posedge clk); #1;
    i_kernel_valid = 1'b1; i_kernel = IN_BW'(999); i_clear = 1'b1;
    @(posedge clk); #1;
    i_kernel_valid = 1'b0; i_clear = 1'b0;
    total++;
    if (o_busy !== 1'b0) begin bad++; $display("FAIL clear busy: got %b want 0", o_busy); end
    play(f2, NB*NC, 0);
    idle(5);
    total++;
    if (obs_s.size() != exp_s.size() || obs_r.size() != exp_r.size()) begin
      bad++; $display("FAIL clear count: got %0d/%0d want %0d/%0d", obs_s.size(), obs_r.size(), exp_s.size(), exp_r.size());
    end
    for (int i = 0; i < obs_s.size() && i < exp_s.size(); i++) begin
      total++;
      if (obs_s[i] != exp_s[i]) begin bad++; $display("FAIL clear score[%0d]: got %0d cls%0d @%0d want %0d cls%0d @%0d", i, obs_s[i].v, obs_s[i].c, obs_s[i].t, exp_s[i].v, exp_s[i].c, exp_s[i].t); end
    end
    for (int i = 0; i < obs_r.size() && i < exp_r.size(); i++) begin
      total++;
      if (obs_r[i] != exp_r[i]) begin bad++; $display("FAIL clear result[%0d]: got %0d cls%0d @%0d want %0d cls%0d @%0d", i, obs_r[i].v, obs_r[i].c, obs_r[i].t, exp_r[i].v, exp_r[i].c, exp_r[i].t); end
    end
    exp_s.delete(); obs_s.delete(); exp_r.delete(); obs_r.delete();
  endtask

  task automatic test_reset_mid();
    frame_t f;
    f = '{1, 2, 3, 4, 5, 5, 5, 5, -1, -1, -1, -1};
    set_bias(10, -5, 0);
    play(f, NB*NC - 1, 0);
    @(posedge clk); #1;
    i_kernel_valid = 1'b1; i_kernel = IN_BW'(f[NB*NC-1]); reset = 1'b1;
    @(posedge clk); #1;
    i_kernel_valid = 1'b0;
    total += 7;
    if (o_score_valid !== 1'b0)  begin bad++; $display("FAIL rstmid score_valid: got %b want 0", o_score_valid); end
    if (o_score !== '0)          begin bad++; $display("FAIL rstmid score: got %0h want 0", o_score); end
    if (o_score_class !== '0)    begin bad++; $display("FAIL rstmid score_class: got %0d want 0", o_score_class); end
    if (o_result_valid !== 1'b0) begin bad++; $display("FAIL rstmid result_valid: got %b want 0", o_result_valid); end
    if (o_result_class !== '0)   begin bad++; $display("FAIL rstmid result_class: got %0d want 0", o_result_class); end
    if (o_result_score !== '0)   begin bad++; $display("FAIL rstmid result_score: got %0h want 0", o_result_score); end
    if (o_busy !== 1'b0)         begin bad++; $display("FAIL rstmid busy: got %b want 0", o_busy); end
    reset = 1'b0;
    idle(5);
    total++;
    if (obs_s.size() != exp_s.size() || obs_r.size() != 0) begin
      bad++; $display("FAIL rstmid count: got %0d/%0d want %0d/0", obs_s.size(), obs_r.size(), exp_s.size());
    end
    for (int i = 0; i < obs_s.size() && i < exp_s.size(); i++) begin
      total++;
      if (obs_s[i] != exp_s[i]) begin bad++; $display("FAIL rstmid score[%0d]: got %0d cls%0d @%0d want %0d cls%0d @%0d", i, obs_s[i].v, obs_s[i].c, obs_s[i].t, exp_s[i].v, exp_s[i].c, exp_s[i].t); end
    end
    exp_s.delete(); obs_s.delete(); exp_r.delete(); obs_r.delete();
  endtask

  task automatic test_extremes();
    frame_t f;
    for (int i = 0; i < NB*NC; i++) f[i] = -(1 << (IN_BW - 1));
    set_bias(-(1 << (B_BW - 1)), -(1 << (B_BW - 1)), -(1 << (B_BW - 1)));
    play(f, NB*NC, 0);
    idle(5);
    total++;
    if (obs_s.size() != exp_s.size() || obs_r.size() != exp_r.size()) begin
      bad++; $display("FAIL extremes count: got %0d/%0d want %0d/%0d", obs_s.size(), obs_r.size(), exp_s.size(), exp_r.size());
    end
    for (int i = 0; i < obs_s.size() && i < exp_s.size(); i++) begin
      total++;
      if (obs_s[i] != exp_s[i]) begin bad++; $display("FAIL extremes score[%0d]: got %0d cls%0d @%0d want %0d cls%0d @%0d", i, obs_s[i].v, obs_s[i].c, obs_s[i].t, exp_s[i].v, exp_s[i].c, exp_s[i].t); end
    end
    for (int i = 0; i < obs_r.size() && i < exp_r.size(); i++) begin
      total++;
      if (obs_r[i] != exp_r[i]) begin bad++; $display("FAIL extremes result[%0d]: got %0d cls%0d @%0d want %0d cls%0d @%0d", i, obs_r[i].v, obs_r[i].c, obs_r[i].t, exp_r[i].v, exp_r[i].c, exp_r[i].t); end
    end
    exp_s.delete(); obs_s.delete(); exp_r.delete(); obs_r.delete();
  endtask

  task automatic test_random();
    frame_t f;
    for (int r = 0; r < 6; r++) begin
      set_bias(int'($urandom_range(0, 65535)) - 32768, int'($urandom_range(0, 65535)) - 32768,
               int'($urandom_range(0, 65535)) - 32768);
      for (int i = 0; i < NB*NC; i++) f[i] = int'($urandom_range(0, (1 << IN_BW) - 1)) - (1 << (IN_BW - 1));
      play(f, NB*NC, (r % 2 == 0) ? 0 : 2);
      idle(5);
    end
    total++;
    if (obs_s.size() != exp_s.size() || obs_r.size() != exp_r.size()) begin
      bad++; $display("FAIL random count: got %0d/%0d want %0d/%0d", obs_s.size(), obs_r.size(), exp_s.size(), exp_r.size());
    end
    for (int i = 0; i < obs_s.size() && i < exp_s.size(); i++) begin
      total++;
      if (obs_s[i] != exp_s[i]) begin bad++; $display("FAIL random score[%0d]: got %0d cls%0d @%0d want %0d cls%0d @%0d", i, obs_s[i].v, obs_s[i].c, obs_s[i].t, exp_s[i].v, exp_s[i].c, exp_s[i].t); end
    end
    for (int i = 0; i < obs_r.size() && i < exp_r.size(); i++) begin
      total++;
      if (obs_r[i] != exp_r[i]) begin bad++; $display("FAIL random result[%0d]: got %0d cls%0d @%0d want %0d cls%0d @%0d", i, obs_r[i].v, obs_r[i].c, obs_r[i].t, exp_r[i].v, exp_r[i].c, exp_r[i].t); end
    end
    exp_s.delete(); obs_s.delete(); exp_r.delete(); obs_r.delete();
  endtask

  initial begin
    test_reset();
    test_contiguous();
    test_gaps();
    test_tie();
    test_back_to_back();
    test_clear();
    test_reset_mid();
    test_extremes();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
